// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encoding, pointer wrap
// and hold-counter width helpers.
package rr_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // The counter only has to reach MAX_HOLD-1, so MAX_HOLD+1 codes is a safe bound.
   function automatic int unsigned hold_width(input int unsigned max_hold);
      return (max_hold == 0) ? 1 : $clog2(max_hold + 1);
   endfunction

   // Explicit wrap so requester counts that are not a power of two still rotate.
   function automatic int unsigned ptr_next(input int unsigned idx,
                                            input int unsigned vect_w);
      return (idx >= vect_w - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the request sources and the arbiter; the
// arbiter uses the slave view, request sources the master view.
interface rr_arbiter_if #(
   parameter int unsigned VECT_W = 8,
   parameter int unsigned BIN_W  = 3
);

   logic [VECT_W-1:0] req;
   logic              done;
   logic [VECT_W-1:0] grant;
   logic [BIN_W-1:0]  grant_idx;
   logic              grant_valid;
   logic              timeout;

   modport master (
      output req, done,
      input  grant, grant_idx, grant_valid, timeout
   );

   modport slave (
      input  req, done,
      output grant, grant_idx, grant_valid, timeout
   );

endinterface

// File: rtl/rr_arbiter_onehot_enc.sv
// One-hot to binary encoder: each index bit is the OR of the one-hot bits
// whose position has that bit set. An all-zero input encodes to 0.
module onehot_enc #(
   parameter int unsigned VECT_W = 8,
   parameter int unsigned BIN_W  = 3
) (
   input  logic [VECT_W-1:0] onehot,
   output logic [BIN_W-1:0]  bin
);

   always_comb begin
      // NOTE: assign every combinational output a default before any branch or
      // loop so no path leaves it unassigned and a latch is never inferred.
      bin = '0;
      for (int unsigned i = 0; i < VECT_W; i++) begin
         if (onehot[i]) begin
            bin = bin | BIN_W'(i);
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant held until done, withdrawal
// or hold timeout, followed by one idle cycle before re-arbitration.
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int unsigned VECT_W   = 8,
   parameter int unsigned BIN_W    = 3,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic        clk,
   input  logic        rst,
   rr_arbiter_if.slave bus
);

   localparam int unsigned HOLD_W = hold_width(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST =
      (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

   state_t              state_q, state_d;
   logic [VECT_W-1:0]   grant_q, grant_d;
   logic [BIN_W-1:0]    ptr_q, ptr_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                timeout_q, timeout_d;

   logic [BIN_W-1:0]    grant_idx;
   logic [VECT_W-1:0]   hi_mask;
   logic [VECT_W-1:0]   req_hi;
   logic [VECT_W-1:0]   cand;
   logic [VECT_W-1:0]   pick;
   logic                owner_req;
   logic                hold_expired;
   logic                release_now;

   onehot_enc #(
      .VECT_W (VECT_W),
      .BIN_W  (BIN_W)
   ) u_enc (
      .onehot (grant_q),
      .bin    (grant_idx)
   );

   // Priority scan from ptr upward with wrap: requesters at or above ptr win;
   // if none, the lowest requester overall wins. No modulo arithmetic needed.
   always_comb begin
      hi_mask = '0;
      for (int unsigned i = 0; i < VECT_W; i++) begin
         hi_mask[i] = (i >= 32'(ptr_q));
      end
      req_hi = bus.req & hi_mask;
      cand   = (req_hi != '0) ? req_hi : bus.req;
      pick   = cand & (~cand + VECT_W'(1));
   end

   assign owner_req    = |(bus.req & grant_q);
   assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
   assign release_now  = bus.done || !owner_req || hold_expired;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.req != '0) begin
               grant_d = pick;
               hold_d  = '0;
               state_d = ST_BUSY;
            end
         end

         ST_BUSY: begin
            if (release_now) begin
               grant_d   = '0;
               hold_d    = '0;
               state_d   = ST_IDLE;
               ptr_d     = BIN_W'(ptr_next(32'(grant_idx), VECT_W));
               // Timeout is reported only when it is the sole reason for release.
               timeout_d = !bus.done && owner_req && hold_expired;
            end else if (MAX_HOLD != 0) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values and the update order inside the block is irrelevant.
      if (rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         ptr_q     <= '0;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_idx   = grant_idx;
   assign bus.grant_valid = (grant_q != '0);
   assign bus.timeout     = timeout_q;

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst)
      $onehot0(grant_q));

   a_idle_no_grant : assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_IDLE) |-> (grant_q == '0));

   a_busy_has_grant : assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_BUSY) |-> $onehot(grant_q));

   a_timeout_idle : assert property (@(posedge clk) disable iff (rst)
      timeout_q |-> (grant_q == '0));

   a_grant_requested : assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_IDLE && bus.req != '0) |=> ((grant_q & $past(bus.req)) == grant_q));

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: scripted stimulus pushes expected
// outputs to a scoreboard that a monitor pops one cycle after each edge.
module tb_rr_arbiter;

   localparam int unsigned VW = 8;
   localparam int unsigned BW = 3;

   typedef struct {
      logic [VW-1:0] grant;
      logic          timeout;
      string         name;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   rr_arbiter_if #(.VECT_W(VW), .BIN_W(BW)) bus ();
   rr_arbiter_if #(.VECT_W(VW), .BIN_W(BW)) bus0 ();

   rr_arbiter #(.VECT_W(VW), .BIN_W(BW), .MAX_HOLD(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   rr_arbiter #(.VECT_W(VW), .BIN_W(BW), .MAX_HOLD(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   function automatic logic [BW-1:0] idx_of(input logic [VW-1:0] g);
      logic [BW-1:0] r;
      r = '0;
      for (int i = 0; i < VW; i++) begin
         if (g[i]) r = BW'(i);
      end
      return r;
   endfunction

   // Monitor: compare every DUT output against the oldest expectation, 1 time unit after the edge.
   always begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         checks++;
         if (bus.grant !== mon_e.grant) begin
            errors++;
            $display("FAIL %s grant: got %h expected %h", mon_e.name, bus.grant, mon_e.grant);
         end
         checks++;
         if (bus.grant_idx !== idx_of(mon_e.grant)) begin
            errors++;
            $display("FAIL %s grant_idx: got %0d expected %0d", mon_e.name, bus.grant_idx, idx_of(mon_e.grant));
         end
         checks++;
         if (bus.grant_valid !== (mon_e.grant != '0)) begin
            errors++;
            $display("FAIL %s grant_valid: got %b expected %b", mon_e.name, bus.grant_valid, (mon_e.grant != '0));
         end
         checks++;
         if (bus.timeout !== mon_e.timeout) begin
            errors++;
            $display("FAIL %s timeout: got %b expected %b", mon_e.name, bus.timeout, mon_e.timeout);
         end
      end
   end

   // Apply inputs for the next edge and queue the outputs expected after it.
   task automatic drive(input logic [VW-1:0] r, input logic d, input logic rs,
                        input logic [VW-1:0] eg, input logic et, input string nm);
      exp_t e;
      e.grant   = eg;
      e.timeout = et;
      e.name    = nm;
      bus.req   = r;
      bus.done  = d;
      rst       = rs;
      sb.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      drive(8'h00, 1'b0, 1'b1, 8'h00, 1'b0, "reset_0");
      drive(8'h00, 1'b0, 1'b1, 8'h00, 1'b0, "reset_1");
      checks++;
      if (bus0.grant !== 8'h00 || bus0.timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold0: got grant %h timeout %b expected 00/0", bus0.grant, bus0.timeout);
      end
   endtask

   task automatic test_rotation();
      for (int i = 0; i < VW; i++) begin
         drive(8'hFF, 1'b0, 1'b0, 8'(1 << i), 1'b0, $sformatf("rotate_grant%0d", i));
         drive(8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, $sformatf("rotate_bubble%0d", i));
      end
      drive(8'hFF, 1'b0, 1'b0, 8'h01, 1'b0, "rotate_wrap_grant");
      drive(8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, "rotate_wrap_bubble");
   endtask

   task automatic test_wrap();
      drive(8'h40, 1'b0, 1'b0, 8'h40, 1'b0, "wrap_serve6");
      drive(8'h40, 1'b1, 1'b0, 8'h00, 1'b0, "wrap_release6");
      drive(8'h81, 1'b0, 1'b0, 8'h80, 1'b0, "wrap_grant7");
      drive(8'h81, 1'b1, 1'b0, 8'h00, 1'b0, "wrap_bubble");
      drive(8'h81, 1'b0, 1'b0, 8'h01, 1'b0, "wrap_grant0");
      drive(8'h81, 1'b1, 1'b0, 8'h00, 1'b0, "wrap_release0");
      drive(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "idle_done_ignored");
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 4; i++) begin
         drive(8'h04, 1'b0, 1'b0, 8'h04, 1'b0, $sformatf("timeout_held%0d", i));
      end
      drive(8'h04, 1'b0, 1'b0, 8'h00, 1'b1, "timeout_pulse");
      drive(8'h04, 1'b0, 1'b0, 8'h04, 1'b0, "timeout_regrant");
      drive(8'h04, 1'b1, 1'b0, 8'h00, 1'b0, "timeout_done_release");
   endtask

   task automatic test_withdraw();
      drive(8'h10, 1'b0, 1'b0, 8'h10, 1'b0, "withdraw_grant");
      drive(8'h10, 1'b0, 1'b0, 8'h10, 1'b0, "withdraw_held");
      drive(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "withdraw_drop");
      drive(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "withdraw_idle");
   endtask

   task automatic test_done_priority();
      for (int i = 0; i < 4; i++) begin
         drive(8'h10, 1'b0, 1'b0, 8'h10, 1'b0, $sformatf("donepri_held%0d", i));
      end
      drive(8'h10, 1'b1, 1'b0, 8'h00, 1'b0, "donepri_release");
      drive(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "donepri_idle");
   endtask

   task automatic test_mid_reset();
      drive(8'h20, 1'b0, 1'b0, 8'h20, 1'b0, "midrst_grant");
      drive(8'h20, 1'b0, 1'b1, 8'h00, 1'b0, "midrst_clear");
      drive(8'h20, 1'b0, 1'b0, 8'h20, 1'b0, "midrst_regrant");
      drive(8'h20, 1'b1, 1'b0, 8'h00, 1'b0, "midrst_release");
      drive(8'h00, 1'b0, 1'b1, 8'h00, 1'b0, "midrst_again");
      drive(8'h41, 1'b0, 1'b0, 8'h01, 1'b0, "midrst_ptr_zero");
      drive(8'h41, 1'b1, 1'b0, 8'h00, 1'b0, "midrst_final_release");
      drive(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "midrst_idle");
   endtask

   task automatic test_no_timeout();
      bus0.req  = 8'h02;
      bus0.done = 1'b0;
      @(posedge clk);
      #2;
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (bus0.grant !== 8'h02 || bus0.grant_idx !== 3'd1 || bus0.timeout !== 1'b0) begin
            errors++;
            $display("FAIL hold0_cycle%0d: got grant %h idx %0d timeout %b expected 02/1/0",
                     i, bus0.grant, bus0.grant_idx, bus0.timeout);
         end
         @(posedge clk);
         #2;
      end
      bus0.done = 1'b1;
      @(posedge clk);
      #2;
      checks++;
      if (bus0.grant !== 8'h00 || bus0.grant_valid !== 1'b0 || bus0.timeout !== 1'b0) begin
         errors++;
         $display("FAIL hold0_release: got grant %h valid %b timeout %b expected 00/0/0",
                  bus0.grant, bus0.grant_valid, bus0.timeout);
      end
      bus0.done = 1'b0;
      bus0.req  = 8'h00;
   endtask

   initial begin
      bus0.req  = '0;
      bus0.done = 1'b0;
      test_reset();
      test_rotation();
      test_wrap();
      test_timeout();
      test_withdraw();
      test_done_priority();
      test_mid_reset();
      test_no_timeout();
      @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter sharing one downstream resource among VECT_W requesters.
- Produces a registered one-hot grant vector and its binary index; the binary index comes from a one-hot-to-binary encoder sub-module.
- Grants are held until the owner releases, withdraws its request, or a hold timeout expires.
- Sits between request sources and the shared datapath; the binary index drives the datapath's source-select mux.

Parameters:
- VECT_W, 8, number of requesters (>=2; need not be a power of 2).
- BIN_W, 3, width of grant index; must equal $clog2(VECT_W).
- MAX_HOLD, 4, maximum consecutive granted cycles per owner; 0 disables the timeout.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  VECT_W  per-requester request level.
- done  input  1  owner release strobe; sampled only while a grant is active.
- grant  output  VECT_W  registered one-hot grant; all-zero when idle.
- grant_idx  output  BIN_W  binary index of the set grant bit; 0 when idle.
- grant_valid  output  1  high whenever grant is non-zero.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold timeout.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - rst is sampled on clk.
  - Reset values: grant=0, grant_idx=0, grant_valid=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0.
  - rst asserted mid-grant: all outputs drop at that same edge; nothing is retained.
- State register: IDLE, BUSY.
- IDLE:
  - If req!=0, select the first set bit scanning ptr, ptr+1, …, VECT_W-1, 0, …, ptr-1.
  - Load grant with that one-hot value, set hold_cnt=0, go to BUSY.
  - Latency: req seen at edge t means grant visible after edge t (registered, 1 cycle).
  - done in IDLE is ignored.
- BUSY: grant is held constant. Release conditions are evaluated every edge, in priority order:
  - (1) done=1.
  - (2) req[grant_idx]=0 (requester withdrew).
  - (3) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1; this sets timeout=1 for the next cycle only.
- Releasing edge:
  - grant is cleared to 0 and state goes to IDLE.
  - ptr becomes grant_idx+1, wrapping VECT_W-1 to 0 explicitly (no power-of-2 reliance).
- One idle bubble cycle always follows each release, then re-arbitration.
  - A lone persistent requester is regranted after the bubble; the wrap-around scan finds it.
- done together with timeout condition: done wins and timeout stays 0.
- hold_cnt:
  - Width $clog2(MAX_HOLD+1) (min 1).
  - Increments each BUSY cycle without release and never overflows.
  - Held at 0 when MAX_HOLD=0.
- grant_idx is derived from the registered grant through the encoder and is consistent with grant in every cycle.
- grant is always one-hot or zero. No grant is ever issued to a requester whose req bit was 0 at the selecting edge.
- Fairness: after any owner k releases, every other continuously-requesting index is served before k is served again.

Decomposition:
- Shared package:
  - State encoding constants (ST_IDLE=1'b0, ST_BUSY=1'b1).
  - Pointer-wrap helper function.
  - HOLD_W derivation.
- One sub-module: onehot_enc (parameters VECT_W, BIN_W), a one-hot-to-binary OR-reduction encoder mapping grant to grant_idx.
- The round-robin priority scan stays inline in rr_arbiter.

Test Plan (VECT_W=8, BIN_W=3, MAX_HOLD=4 unless stated):
- Reset then rotation: rst for 2 cycles, then req=8'hFF held; pulse done on each first granted cycle → grant sequence 01,02,04,…,80,01 with idx 0..7,0. Each grant lasts 1 cycle with a 1-cycle zero bubble between; timeout stays 0.
- Wrap-around: ptr driven to 7 (serve idx 6 first), then req=8'h81 → grant 8'h80 (idx 7); on done → bubble → 8'h01 (idx 0).
- Timeout: req=8'h04 held, done=0 → grant 8'h04 for exactly 4 cycles; timeout=1 for the single bubble cycle; then grant 8'h04 again.
- Withdrawal and done priority: req=8'h10 for 2 cycles then 0 → grant drops on the edge req falls, no timeout. Separately, done=1 on 4th held cycle → release with timeout=0.
- Mid-grant reset: grant 8'h20 active, rst=1 one cycle with req still 8'h20 → grant=0, idx=0, valid=0 after that edge. Regrant of 8'h20 one cycle after rst deasserts, with ptr back at 0.
- MAX_HOLD=0 build: req=8'h02 held 20 cycles, done=0 → grant 8'h02 held all 20 cycles, timeout never asserts.
